fire6_expand1_ofm_writer: RTL and testbench

Drains the per-pixel output vector of the `fire6_expand1` convolution layer into the next layer's feature-map RAM. Sits directly downstream of the layer and consumes its `fire6_expand1_sample` pulse and `ofm` array. Each pixel's `DSP_NO` channels are serialised into `LANES`-wide RAM writes. After the last pixel is stored, the block returns `ram_feedback` to the layer.

---
 rtl/fire_pkg.sv | 35 +++
 rtl/ofm_lane_mux.sv | 35 +++
 rtl/fire6_expand1_ofm_writer.sv | 166 ++++++++++++++++
 tb/tb_fire6_expand1_ofm_writer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fire_pkg.sv
// -----------------------------------------------------------------------------
// fire_pkg
// Shared constants and types for the fire6 layer and its output writer.
//   WIDTH, DSP_NO, WOUT : activation width, channels per pixel, output size
//   wr_state_t          : writer state machine encoding
//   calc_beats          : RAM write beats per pixel
//   calc_addr_w         : RAM word-address width for one full layer
// -----------------------------------------------------------------------------
package fire_pkg;

   localparam int WIDTH  = 16;
   localparam int DSP_NO = 256;
   localparam int WOUT   = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } wr_state_t;

   function automatic int calc_beats(input int dsp_no, input int lanes);
      return dsp_no / lanes;
   endfunction

   // Smallest n with 2**n >= number of words in one layer (at least 1).
   function automatic int calc_addr_w(input int wout, input int beats);
      int words;
      int n;
      words = wout * wout * beats;
      n     = 0;
      while ((1 << n) < words) n++;
      return (n < 1) ? 1 : n;
   endfunction

endpackage

// File: rtl/ofm_lane_mux.sv
// -----------------------------------------------------------------------------
// ofm_lane_mux
// Combinational selector: picks the LANES activations belonging to one write
// beat out of a full pixel vector and packs them, lane k at [k*WIDTH +: WIDTH].
//   src   : in,  WIDTH x [0:DSP_NO-1] pixel vector
//   beat  : in,  beat index, 0 .. DSP_NO/LANES-1
//   lanes : out, LANES*WIDTH packed write word
// -----------------------------------------------------------------------------
module ofm_lane_mux #(
   parameter  int WIDTH  = fire_pkg::WIDTH,
   parameter  int DSP_NO = fire_pkg::DSP_NO,
   parameter  int LANES  = 8,
   localparam int BEATS  = DSP_NO / LANES,
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic [WIDTH-1:0]       src [0:DSP_NO-1],
   input  logic [BEAT_W-1:0]      beat,
   output logic [LANES*WIDTH-1:0] lanes
);

   // Decoded one-hot select per beat keeps every array index a constant.
   // NOTE: every variable written in always_comb gets a default first, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      lanes = '0;
      for (int b = 0; b < BEATS; b++) begin
         if (beat == BEAT_W'(b)) begin
            for (int k = 0; k < LANES; k++) begin
               lanes[k*WIDTH +: WIDTH] = src[b*LANES + k];
            end
         end
      end
   end

endmodule

// File: rtl/fire6_expand1_ofm_writer.sv
// -----------------------------------------------------------------------------
// fire6_expand1_ofm_writer
// Drains each fire6_expand1 output pixel (DSP_NO channels) into the next
// layer's feature-map RAM as BEATS consecutive LANES-wide writes, then pulses
// ram_feedback_o once the whole WOUT x WOUT layer is stored.
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   sample_i        : one-cycle pulse, ofm_i valid in that cycle
//   ofm_i           : WIDTH x [0:DSP_NO-1] per-channel activations
//   wr_en_o         : RAM write strobe
//   wr_addr_o       : RAM word address, pix*BEATS + beat
//   wr_data_o       : packed write word, lane k = shadow[beat*LANES+k]
//   ram_feedback_o  : one-cycle pulse, first cycle in DONE
//   busy_o          : high while draining a pixel
//   overflow_o      : sticky, a sample was dropped
// All outputs are registered; the next-cycle values are computed from the
// FSM's next state so the first beat appears the cycle after the capture.
// -----------------------------------------------------------------------------
module fire6_expand1_ofm_writer
   import fire_pkg::*;
#(
   parameter  int WIDTH  = fire_pkg::WIDTH,
   parameter  int DSP_NO = fire_pkg::DSP_NO,
   parameter  int LANES  = 8,
   parameter  int WOUT   = fire_pkg::WOUT,
   localparam int BEATS  = calc_beats(DSP_NO, LANES),
   localparam int ADDR_W = calc_addr_w(WOUT, BEATS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   sample_i,
   input  logic [WIDTH-1:0]       ofm_i [0:DSP_NO-1],
   output logic                   wr_en_o,
   output logic [ADDR_W-1:0]      wr_addr_o,
   output logic [LANES*WIDTH-1:0] wr_data_o,
   output logic                   ram_feedback_o,
   output logic                   busy_o,
   output logic                   overflow_o
);

   localparam int PIXELS = WOUT * WOUT;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   // One extra bit: pix counts up to PIXELS after the final pixel.
   localparam int PIX_W  = $clog2(PIXELS + 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
   localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(PIXELS - 1);

   wr_state_t              state, state_next;
   logic [BEAT_W-1:0]      beat, beat_next;
   logic [PIX_W-1:0]       pix, pix_next;
   logic                   capture;
   logic                   drop;
   logic                   wr_en_next;
   logic                   feedback_next;
   logic [ADDR_W-1:0]      addr_next;
   logic [LANES*WIDTH-1:0] lane_word;
   logic [WIDTH-1:0]       shadow  [0:DSP_NO-1];
   logic [WIDTH-1:0]       mux_src [0:DSP_NO-1];

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next    = state;
      beat_next     = beat;
      pix_next      = pix;
      capture       = 1'b0;
      drop          = 1'b0;
      wr_en_next    = 1'b0;
      feedback_next = 1'b0;
      case (state)
         IDLE: begin
            if (sample_i) begin
               capture    = 1'b1;
               beat_next  = '0;
               wr_en_next = 1'b1;
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (beat == LAST_BEAT) begin
               pix_next = pix + 1'b1;
               if (pix == LAST_PIX) begin
                  // Layer complete; a sample landing here has nowhere to go.
                  state_next    = DONE;
                  feedback_next = 1'b1;
                  drop          = sample_i;
               end else if (sample_i) begin
                  // Back-to-back pixel: restart at beat 0 with no idle cycle.
                  capture    = 1'b1;
                  beat_next  = '0;
                  wr_en_next = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               beat_next  = beat + 1'b1;
               wr_en_next = 1'b1;
               drop       = sample_i;
            end
         end
         DONE: begin
            drop = sample_i;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------- data select
   // On a capture cycle the first beat must come straight from ofm_i, since
   // the shadow buffer only holds it after this edge.
   always_comb begin
      if (capture) mux_src = ofm_i;
      else         mux_src = shadow;
   end

   ofm_lane_mux #(
      .WIDTH  (WIDTH),
      .DSP_NO (DSP_NO),
      .LANES  (LANES)
   ) u_lane_mux (
      .src   (mux_src),
      .beat  (beat_next),
      .lanes (lane_word)
   );

   assign addr_next = ADDR_W'(int'(pix_next) * BEATS + int'(beat_next));

   // ------------------------------------------- counters, buffer, outputs
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   // NOTE: the shadow buffer is a flop array, not a RAM macro, and is reset so
   // that it reads zero after rst like every other piece of state here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat           <= '0;
         pix            <= '0;
         wr_en_o        <= 1'b0;
         busy_o         <= 1'b0;
         wr_addr_o      <= '0;
         wr_data_o      <= '0;
         ram_feedback_o <= 1'b0;
         overflow_o     <= 1'b0;
         for (int c = 0; c < DSP_NO; c++) shadow[c] <= '0;
      end else begin
         beat           <= beat_next;
         pix            <= pix_next;
         wr_en_o        <= wr_en_next;
         busy_o         <= wr_en_next;
         ram_feedback_o <= feedback_next;
         if (drop)       overflow_o <= 1'b1;
         if (wr_en_next) begin
            wr_addr_o <= addr_next;
            wr_data_o <= lane_word;
         end
         if (capture) begin
            for (int c = 0; c < DSP_NO; c++) shadow[c] <= ofm_i[c];
         end
      end
   end

endmodule

// File: tb/tb_fire6_expand1_ofm_writer.sv
// -----------------------------------------------------------------------------
// tb_fire6_expand1_ofm_writer
// Directed bench for the fire6_expand1 OFM writer. A negedge monitor logs every
// RAM write (address, data, cycle); scenario tasks compare the log and the
// flag outputs with hand-computed values and a small packing model.
// -----------------------------------------------------------------------------
module tb_fire6_expand1_ofm_writer;
   import fire_pkg::*;

   localparam int LANES  = 8;
   localparam int BEATS  = DSP_NO / LANES;
   localparam int ADDR_W = 13;
   localparam int WW     = LANES * WIDTH;

   logic              clk = 1'b0;
   logic              rst;
   logic              sample_i;
   logic [WIDTH-1:0]  ofm_i [0:DSP_NO-1];
   logic              wr_en_o;
   logic [ADDR_W-1:0] wr_addr_o;
   logic [WW-1:0]     wr_data_o;
   logic              ram_feedback_o;
   logic              busy_o;
   logic              overflow_o;

   fire6_expand1_ofm_writer #(
      .WIDTH  (WIDTH),
      .DSP_NO (DSP_NO),
      .LANES  (LANES),
      .WOUT   (WOUT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .sample_i       (sample_i),
      .ofm_i          (ofm_i),
      .wr_en_o        (wr_en_o),
      .wr_addr_o      (wr_addr_o),
      .wr_data_o      (wr_data_o),
      .ram_feedback_o (ram_feedback_o),
      .busy_o         (busy_o),
      .overflow_o     (overflow_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Posedge counter; a write logged with value E was launched by edge E.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [ADDR_W-1:0] q_addr [$];
   logic [WW-1:0]     q_data [$];
   int                q_cyc  [$];
   int                busy_cnt;
   int                fb_cnt;
   int                fb_cyc;

   always @(negedge clk) begin
      if (wr_en_o) begin
         q_addr.push_back(wr_addr_o);
         q_data.push_back(wr_data_o);
         q_cyc.push_back(cyc);
      end
      if (busy_o)         busy_cnt <= busy_cnt + 1;
      if (ram_feedback_o) begin
         fb_cnt <= fb_cnt + 1;
         fb_cyc <= cyc;
      end
   end

   // Pixel vectors used as stimulus and as the reference for expected data.
   logic [WIDTH-1:0] exp_px [0:3][0:DSP_NO-1];

   function automatic logic [WW-1:0] model_word(input int p, input int b);
      logic [WW-1:0] w;
      w = '0;
      for (int k = 0; k < LANES; k++) w[k*WIDTH +: WIDTH] = exp_px[p][b*LANES + k];
      return w;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_log();
      q_addr.delete();
      q_data.delete();
      q_cyc.delete();
      busy_cnt = 0;
      fb_cnt   = 0;
      fb_cyc   = -1;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      sample_i = 1'b0;
      tick(2);
      rst = 1'b0;
      tick(1);
      clear_log();
   endtask

   // Presents exp_px[p] with a sample pulse; edge_cyc is the capturing edge.
   task automatic send_pixel(input int p, output int edge_cyc);
      for (int c = 0; c < DSP_NO; c++) ofm_i[c] = exp_px[p][c];
      sample_i = 1'b1;
      tick(1);
      sample_i = 1'b0;
      edge_cyc = cyc;
   endtask

   // -------------------------------------------------------------- tests
   task automatic test_reset();
      rst      = 1'b1;
      sample_i = 1'b0;
      for (int c = 0; c < DSP_NO; c++) ofm_i[c] = '0;
      #2;
      n_checks++; if (wr_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", wr_en_o); end
      n_checks++; if (wr_addr_o !== '0) begin n_fail++; $display("FAIL reset_addr: got %0h want 0", wr_addr_o); end
      n_checks++; if (wr_data_o !== '0) begin n_fail++; $display("FAIL reset_data: got %0h want 0", wr_data_o); end
      n_checks++; if (ram_feedback_o !== 1'b0) begin n_fail++; $display("FAIL reset_feedback: got %b want 0", ram_feedback_o); end
      n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
      n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow_o); end
      tick(2);
      rst = 1'b0;
      clear_log();
      tick(5);
      n_checks++; if (q_addr.size() != 0 || busy_cnt != 0) begin n_fail++; $display("FAIL idle_no_write: writes %0d busy %0d want 0 0", q_addr.size(), busy_cnt); end
   endtask

   task automatic test_single_pixel();
      int e;
      int bad;
      logic [WW-1:0] w;
      do_reset();
      for (int c = 0; c < DSP_NO; c++) exp_px[0][c] = WIDTH'(c);
      send_pixel(0, e);
      tick(40);
      n_checks++; if (q_addr.size() != BEATS) begin n_fail++; $display("FAIL single_count: got %0d want %0d", q_addr.size(), BEATS); end
      if (q_addr.size() == BEATS) begin
         bad = 0;
         for (int i = 0; i < BEATS; i++) if (q_addr[i] !== ADDR_W'(i)) bad++;
         n_checks++; if (bad != 0) begin n_fail++; $display("FAIL single_addr: %0d bad addresses, want 0..31", bad); end
         n_checks++; if (q_cyc[0] != e) begin n_fail++; $display("FAIL single_latency: first write cycle %0d want %0d", q_cyc[0], e); end
         n_checks++; if (q_data[0] !== 128'h0007_0006_0005_0004_0003_0002_0001_0000) begin n_fail++; $display("FAIL single_beat0: got %h want 0007000600050004000300020001_0000", q_data[0]); end
         w = q_data[31];
         n_checks++; if (w[127:112] !== 16'd255) begin n_fail++; $display("FAIL single_beat31_lane7: got %0d want 255", w[127:112]); end
      end
      n_checks++; if (busy_cnt != BEATS) begin n_fail++; $display("FAIL single_busy: got %0d cycles want %0d", busy_cnt, BEATS); end
      n_checks++; if (fb_cnt != 0) begin n_fail++; $display("FAIL single_feedback: got %0d pulses want 0", fb_cnt); end
   endtask

   task automatic test_back_to_back();
      int e;
      int bad;
      do_reset();
      for (int p = 0; p < 3; p++)
         for (int c = 0; c < DSP_NO; c++) exp_px[p][c] = WIDTH'(p*256 + c);
      for (int p = 0; p < 3; p++) begin
         send_pixel(p, e);
         tick(64);
      end
      n_checks++; if (q_addr.size() != 3*BEATS) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", q_addr.size(), 3*BEATS); end
      if (q_addr.size() == 3*BEATS) begin
         bad = 0;
         for (int i = 0; i < 3*BEATS; i++) if (q_addr[i] !== ADDR_W'(i)) bad++;
         n_checks++; if (bad != 0) begin n_fail++; $display("FAIL b2b_addr: %0d bad addresses, want 0..95", bad); end
         bad = 0;
         for (int i = 0; i < 3*BEATS; i++) if (q_data[i] !== model_word(i / BEATS, i % BEATS)) bad++;
         n_checks++; if (bad != 0) begin n_fail++; $display("FAIL b2b_data: %0d bad words, want 0", bad); end
         n_checks++; if (q_data[BEATS] !== model_word(1, 0)) begin n_fail++; $display("FAIL b2b_pix1_beat0: got %h want %h", q_data[BEATS], model_word(1, 0)); end
      end
      n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL b2b_overflow: got %b want 0", overflow_o); end
   endtask

   task automatic test_last_beat_sample();
      int e0;
      int e1;
      int bad;
      do_reset();
      send_pixel(0, e0);
      tick(BEATS - 1);
      send_pixel(1, e1);
      tick(40);
      n_checks++; if (q_addr.size() != 2*BEATS) begin n_fail++; $display("FAIL lastbeat_count: got %0d want %0d", q_addr.size(), 2*BEATS); end
      if (q_addr.size() == 2*BEATS) begin
         bad = 0;
         for (int i = 0; i < 2*BEATS; i++) if (q_addr[i] !== ADDR_W'(i) || q_cyc[i] != e0 + i) bad++;
         n_checks++; if (bad != 0) begin n_fail++; $display("FAIL lastbeat_gapless: %0d bad address/cycle entries, want 0", bad); end
         bad = 0;
         for (int i = 0; i < BEATS; i++) if (q_data[BEATS + i] !== model_word(1, i)) bad++;
         n_checks++; if (bad != 0) begin n_fail++; $display("FAIL lastbeat_data: %0d bad words, want 0", bad); end
      end
      n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL lastbeat_overflow: got %b want 0", overflow_o); end
   endtask

   task automatic test_drop_sample();
      int e0;
      int e1;
      int bad;
      do_reset();
      send_pixel(0, e0);
      tick(10);
      send_pixel(1, e1);
      tick(40);
      n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL drop_overflow: got %b want 1", overflow_o); end
      n_checks++; if (q_addr.size() != BEATS) begin n_fail++; $display("FAIL drop_count: got %0d want %0d", q_addr.size(), BEATS); end
      if (q_addr.size() == BEATS) begin
         bad = 0;
         for (int i = 0; i < BEATS; i++) if (q_addr[i] !== ADDR_W'(i) || q_data[i] !== model_word(0, i)) bad++;
         n_checks++; if (bad != 0) begin n_fail++; $display("FAIL drop_data: %0d bad writes, want 0", bad); end
      end
      n_checks++; if (busy_cnt != BEATS) begin n_fail++; $display("FAIL drop_busy: got %0d want %0d", busy_cnt, BEATS); end
   endtask

   task automatic test_reset_mid_drain();
      int e;
      int bad;
      do_reset();
      send_pixel(0, e);
      tick(15);
      n_checks++; if (wr_en_o !== 1'b1 || wr_addr_o !== ADDR_W'(15)) begin n_fail++; $display("FAIL mid_pre_reset: wr_en %b addr %0d want 1 15", wr_en_o, wr_addr_o); end
      rst = 1'b1;
      #1;
      n_checks++; if (wr_en_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL mid_reset_en: wr_en %b busy %b want 0 0", wr_en_o, busy_o); end
      n_checks++; if (wr_addr_o !== '0 || wr_data_o !== '0) begin n_fail++; $display("FAIL mid_reset_bus: addr %0h data %0h want 0 0", wr_addr_o, wr_data_o); end
      n_checks++; if (ram_feedback_o !== 1'b0 || overflow_o !== 1'b0) begin n_fail++; $display("FAIL mid_reset_flags: fb %b ovf %b want 0 0", ram_feedback_o, overflow_o); end
      tick(2);
      rst = 1'b0;
      tick(1);
      clear_log();
      send_pixel(1, e);
      tick(40);
      n_checks++; if (q_addr.size() != BEATS) begin n_fail++; $display("FAIL mid_restart_count: got %0d want %0d", q_addr.size(), BEATS); end
      if (q_addr.size() == BEATS) begin
         bad = 0;
         for (int i = 0; i < BEATS; i++) if (q_addr[i] !== ADDR_W'(i) || q_data[i] !== model_word(1, i)) bad++;
         n_checks++; if (bad != 0) begin n_fail++; $display("FAIL mid_restart_writes: %0d bad writes, want 0", bad); end
      end
   endtask

   task automatic test_random();
      int e;
      int bad;
      do_reset();
      for (int p = 0; p < 4; p++)
         for (int c = 0; c < DSP_NO; c++) exp_px[p][c] = WIDTH'($urandom_range(0, 65535));
      for (int p = 0; p < 4; p++) begin
         send_pixel(p, e);
         tick(39);
      end
      tick(10);
      n_checks++; if (q_addr.size() != 4*BEATS) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", q_addr.size(), 4*BEATS); end
      if (q_addr.size() == 4*BEATS) begin
         bad = 0;
         for (int i = 0; i < 4*BEATS; i++)
            if (q_addr[i] !== ADDR_W'(i) || q_data[i] !== model_word(i / BEATS, i % BEATS)) bad++;
         n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rand_packing: %0d bad writes, want 0", bad); end
      end
      n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL rand_overflow: got %b want 0", overflow_o); end
   endtask

   task automatic test_full_layer();
      int e;
      int bad;
      int last;
      do_reset();
      for (int c = 0; c < DSP_NO; c++) exp_px[0][c] = WIDTH'(16'hA000 + c);
      for (int p = 0; p < WOUT*WOUT; p++) begin
         send_pixel(0, e);
         tick(BEATS - 1);
      end
      tick(10);
      n_checks++; if (q_addr.size() != WOUT*WOUT*BEATS) begin n_fail++; $display("FAIL full_count: got %0d want %0d", q_addr.size(), WOUT*WOUT*BEATS); end
      if (q_addr.size() == WOUT*WOUT*BEATS) begin
         last = WOUT*WOUT*BEATS - 1;
         bad  = 0;
         for (int i = 0; i <= last; i++) if (q_addr[i] !== ADDR_W'(i)) bad++;
         n_checks++; if (bad != 0) begin n_fail++; $display("FAIL full_addr: %0d bad addresses, want 0", bad); end
         n_checks++; if (q_addr[last] !== 13'd8191) begin n_fail++; $display("FAIL full_last_addr: got %0d want 8191", q_addr[last]); end
         n_checks++; if (q_data[last] !== model_word(0, BEATS - 1)) begin n_fail++; $display("FAIL full_last_data: got %h want %h", q_data[last], model_word(0, BEATS - 1)); end
         n_checks++; if (fb_cyc != q_cyc[last] + 1) begin n_fail++; $display("FAIL full_fb_timing: pulse cycle %0d want %0d", fb_cyc, q_cyc[last] + 1); end
      end
      n_checks++; if (fb_cnt != 1) begin n_fail++; $display("FAIL full_fb_count: got %0d pulses want 1", fb_cnt); end
      n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL full_overflow_early: got %b want 0", overflow_o); end
      clear_log();
      send_pixel(0, e);
      tick(40);
      n_checks++; if (q_addr.size() != 0 || busy_cnt != 0) begin n_fail++; $display("FAIL done_no_write: writes %0d busy %0d want 0 0", q_addr.size(), busy_cnt); end
      n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL done_overflow: got %b want 1", overflow_o); end
      n_checks++; if (fb_cnt != 0) begin n_fail++; $display("FAIL done_fb_repeat: got %0d pulses want 0", fb_cnt); end
   endtask

   initial begin
      test_reset();
      test_single_pixel();
      test_back_to_back();
      test_last_beat_sample();
      test_drop_sample();
      test_reset_mid_drain();
      test_random();
      test_full_layer();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
